// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double dabble: a digit of 8 or more after a right
// shift received half of ten from above, so 3 is taken off to keep it decimal.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble) with start/busy/done handshake.
// Define BCD2BIN_CHECK_EN to reject words containing a digit above 9 (err=1, bin_out=0).
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t           state;
  logic [BCD_W-1:0] bcd_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_shift;

  // One step of the combined {bcd_reg, bin_reg} right shift; correction applies to the shifted digits.
  assign bcd_shift = bcd_reg >> 1;
  assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic in_invalid;
  logic err_q;

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) in_invalid = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // The last SHIFT cycle loads bin_out and raises done so both are valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
            if (in_invalid) begin
              state   <= DONE;
              done    <= 1'b1;
              bin_out <= '0;
              err_q   <= 1'b1;
            end else begin
              state   <= SHIFT;
            end
`else
            state   <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_shift;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            bin_out <= bin_shift;
`ifdef BCD2BIN_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq; expected values come from a decimal-arithmetic model.
// Honours BCD2BIN_CHECK_EN when defined for the build.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int LAT    = BIN_W + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       bcd_in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Decimal value of a packed BCD word, digit 0 least significant.
  function automatic int ref_value(input logic [7:0] w);
    int v;
    int mul;
    v = 0;
    mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(w[i*4 +: 4]) * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic logic [7:0] rand_bcd();
    logic [7:0] w;
    w[3:0] = 4'($urandom_range(0, 9));
    w[7:4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  // Launch one conversion and report the cycle of done (cycle 1 = first after acceptance).
  task automatic run_conv(input logic [7:0] v, output int done_cyc, output int busy_cycles,
                          output logic [BIN_W-1:0] res, output logic res_err,
                          output logic done_next, output logic busy_next);
    int cyc;
    done_cyc = -1;
    busy_cycles = 0;
    res = '0;
    res_err = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        res = bin_out;
        res_err = err;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    done_next = done;
    busy_next = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bcd_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (bin_out !== '0) begin bad++; $display("[TB] FAIL reset_bin got=%0d want=0", bin_out); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_known();
    logic [7:0] vals [4] = '{8'h99, 8'h00, 8'h10, 8'h07};
    int dc, bc;
    logic [BIN_W-1:0] r;
    logic e, dn, bn;
    foreach (vals[i]) begin
      run_conv(vals[i], dc, bc, r, e, dn, bn);
      total++; if (dc !== LAT) begin bad++; $display("[TB] FAIL known_latency bcd=%h got=%0d want=%0d", vals[i], dc, LAT); end
      total++; if (bc !== LAT) begin bad++; $display("[TB] FAIL known_busy bcd=%h got=%0d want=%0d", vals[i], bc, LAT); end
      total++; if (r !== BIN_W'(ref_value(vals[i]))) begin bad++; $display("[TB] FAIL known_bin bcd=%h got=%0d want=%0d", vals[i], r, ref_value(vals[i])); end
      total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL known_err bcd=%h got=%b want=0", vals[i], e); end
      total++; if (dn !== 1'b0 || bn !== 1'b0) begin bad++; $display("[TB] FAIL known_after bcd=%h got done=%b busy=%b want 0/0", vals[i], dn, bn); end
      total++; if (bin_out !== BIN_W'(ref_value(vals[i]))) begin bad++; $display("[TB] FAIL known_hold bcd=%h got=%0d want=%0d", vals[i], bin_out, ref_value(vals[i])); end
    end
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    int first = -1;
    logic [BIN_W-1:0] r = '0;
    @(negedge clk);
    start = 1'b1;
    bcd_in = 8'h42;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc == 3) begin start = 1'b1; bcd_in = 8'h55; end
      if (cyc == 4) start = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) begin first = cyc; r = bin_out; end
      end
      @(negedge clk);
    end
    total++; if (n_done !== 1) begin bad++; $display("[TB] FAIL ignore_count got=%0d want=1", n_done); end
    total++; if (first !== LAT) begin bad++; $display("[TB] FAIL ignore_latency got=%0d want=%0d", first, LAT); end
    total++; if (r !== BIN_W'(42)) begin bad++; $display("[TB] FAIL ignore_bin got=%0d want=42", r); end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    int dc, bc;
    logic [BIN_W-1:0] r;
    logic e, dn, bn;
    @(negedge clk);
    start = 1'b1;
    bcd_in = 8'h87;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    total++; if (bin_out !== '0) begin bad++; $display("[TB] FAIL abort_bin got=%0d want=0", bin_out); end
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    total++; if (n_done !== 0) begin bad++; $display("[TB] FAIL abort_done got=%0d want=0", n_done); end
    run_conv(8'h87, dc, bc, r, e, dn, bn);
    total++; if (dc !== LAT) begin bad++; $display("[TB] FAIL restart_latency got=%0d want=%0d", dc, LAT); end
    total++; if (r !== BIN_W'(87)) begin bad++; $display("[TB] FAIL restart_bin got=%0d want=87", r); end
  endtask

  task automatic test_check();
    int dc, bc;
    logic [BIN_W-1:0] r;
    logic e, dn, bn;
    run_conv(8'h3A, dc, bc, r, e, dn, bn);
`ifdef BCD2BIN_CHECK_EN
    total++; if (dc !== 1) begin bad++; $display("[TB] FAIL check_latency got=%0d want=1", dc); end
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL check_err got=%b want=1", e); end
    total++; if (r !== '0) begin bad++; $display("[TB] FAIL check_bin got=%0d want=0", r); end
`else
    total++; if (dc !== LAT) begin bad++; $display("[TB] FAIL nocheck_latency got=%0d want=%0d", dc, LAT); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL nocheck_err got=%b want=0", e); end
`endif
    run_conv(8'h36, dc, bc, r, e, dn, bn);
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL check_clear_err got=%b want=0", e); end
    total++; if (r !== BIN_W'(36)) begin bad++; $display("[TB] FAIL check_clear_bin got=%0d want=36", r); end
  endtask

  task automatic test_random();
    int dc, bc;
    logic [BIN_W-1:0] r;
    logic e, dn, bn;
    logic [7:0] v;
    for (int i = 0; i < 20; i++) begin
      v = rand_bcd();
      run_conv(v, dc, bc, r, e, dn, bn);
      total++;
      if (dc !== LAT || r !== BIN_W'(ref_value(v)) || e !== 1'b0) begin
        bad++;
        $display("[TB] FAIL random bcd=%h got bin=%0d err=%b lat=%0d want bin=%0d err=0 lat=%0d",
                 v, r, e, dc, ref_value(v), LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int last_done = -1;
    int cyc = 0;
    logic [7:0] v;
    @(negedge clk);
    v = 8'h00;
    bcd_in = v;
    start = 1'b1;
    while (idx < 100 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        total++;
        if (bin_out !== BIN_W'(idx)) begin
          bad++;
          $display("[TB] FAIL sweep_bin idx=%0d got=%0d want=%0d", idx, bin_out, idx);
        end
        if (last_done >= 0) begin
          total++;
          if (cyc - last_done !== BIN_W + 2) begin
            bad++;
            $display("[TB] FAIL sweep_spacing idx=%0d got=%0d want=%0d", idx, cyc - last_done, BIN_W + 2);
          end
        end
        last_done = cyc;
        idx++;
        v[3:0] = 4'(idx % 10);
        v[7:4] = 4'((idx / 10) % 10);
        bcd_in = v;
      end
    end
    start = 1'b0;
    total++; if (idx !== 100) begin bad++; $display("[TB] FAIL sweep_timeout got=%0d want=100", idx); end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bcd_in = 8'h00;
    test_reset();
    test_known();
    test_busy_ignore();
    test_reset_abort();
    test_check();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
